ram_b_loader: RTL
=================

Name: ram_b_loader

Overview:
- Writer-side master for the 64x32 single-port block RAM (RAM_B) on port A.
- Shares the same addra/douta interface and the 1-cycle synchronous read latency as ROM_B.
- Takes a byte stream with a valid/ready handshake, packs 4 bytes into each 32-bit word, and writes WORDS words from address 0 upward.
- Then reads every written word back, compares a wrapping checksum against the one taken during writing, and reports done/err to the boot sequencer.

Parameters:
- WORDS, 64, number of words loaded per run; legal range 1..64.
- ADDR_W, 6, RAM address width; must satisfy 2**ADDR_W >= WORDS.
- DATA_W, 32, RAM word width; fixed at 4 bytes.

Ports:
- clka  in  1  clock; all logic on rising edge.
- rsta  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy=1.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle (registered).
- wea  out  1  RAM write enable.
- addra  out  ADDR_W  RAM address.
- dina  out  DATA_W  RAM write data.
- douta  in  DATA_W  RAM read data; valid one cycle after the clock edge that samples addra.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start or reset.
- err  out  1  checksum mismatch; valid while done=1.
- sum  out  DATA_W  write-side checksum of the last run.

Behaviour:
- Clocking: single clock clka; rsta is synchronous and active-high.
- Reset: state IDLE. byte_ready, wea, busy, done, err = 0. addra, dina, sum = 0. Byte counter and read-back accumulator = 0.
  - rsta has priority over all other inputs, including mid-run. wea is 0 from the first edge with rsta=1.
  - RAM contents are not restored after a mid-run reset.
- IDLE: on start=1, go to COLLECT. Set addra=0, sum=0, byte count=0, done=0, err=0, busy=1.
- COLLECT: byte_ready=1.
  - A byte is taken only on a cycle with byte_valid && byte_ready.
  - Byte k (k=0..3) lands in dina[8k+7:8k]; the first byte goes to the LSB.
  - The 4th accepted byte moves the FSM to WRITE on the next edge. byte_ready drops at that same edge, so no 5th byte is taken.
  - byte_valid gaps stall COLLECT with no timeout.
- WRITE: one cycle exactly; wea=1 with dina and addra stable; sum <= sum + dina, wrapping mod 2**32.
  - If addra==WORDS-1: go to VERIFY with addra=0.
  - Otherwise: addra+1, byte count=0, return to COLLECT.
- VERIFY: wea=0, byte_ready=0.
  - addra steps 0..WORDS-1, one address per cycle.
  - A delayed-valid flag aligns each douta with its address. The accumulator adds douta in the cycle after the edge that sampled the address.
  - VERIFY lasts WORDS+1 cycles, including the pipeline drain; then go to DONE.
- DONE: busy=0, done=1, err=(readback_sum != sum).
  - addra holds WORDS-1; sum holds.
  - start in DONE begins a new run, same as from IDLE.
- start while busy=1 is ignored, with no effect on state or counters.
- WORDS=1: a single WRITE cycle, then VERIFY runs 2 cycles.
- Address never wraps: the terminal address is WORDS-1.

Decomposition:
- Package ram_b_pkg holds:
  - the state enum (IDLE, COLLECT, WRITE, VERIFY, DONE);
  - RAM_B_ADDR_W=6, RAM_B_DATA_W=32, RAM_B_DEPTH=64;
  - BYTES_PER_WORD=4.
- One sub-module, byte_packer: 2-bit counter plus a 32-bit shift/insert register.
  - Inputs: clk, rst, take, clear.
  - Outputs: word, word_full.
  - The FSM and verify pipeline stay in ram_b_loader.

Test Plan:
- Reset mid-COLLECT (after 2 bytes) -> next cycle wea=0, byte_ready=0, busy=0, addra=0. A following start with a 4-byte load writes a clean word, with no leftover bytes.
- WORDS=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with byte_valid held high -> two single-cycle wea pulses:
  - addra=0, dina=0x44332211;
  - addra=1, dina=0x88776655.
  - Then sum=0xCCAA8866, done=1, err=0.
- byte_valid toggling 1-0-1-0 every cycle -> word contents identical to the previous case; byte_ready never high in WRITE/VERIFY; wea high exactly WORDS cycles total.
- Behavioural RAM model that flips bit 0 of the word at addr 1 on write, WORDS=2 -> done=1, err=1, sum=0xCCAA8866.
- start pulsed during COLLECT and VERIFY -> ignored, with identical waveforms to a run without the extra pulses. start in DONE -> done=0 the next cycle, busy=1, addra=0.
- WORDS=64 with an incrementing byte pattern 0x00..0xFF repeating -> the last write is at addra=63, no address wrap, VERIFY lasts 65 cycles, err=0.

Source files
------------

// File: rtl/ram_b_pkg.sv
// Shared types and sizing for the RAM_B writer/loader.
package ram_b_pkg;

  localparam int RAM_B_ADDR_W   = 6;
  localparam int RAM_B_DATA_W   = 32;
  localparam int RAM_B_DEPTH    = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    VERIFY,
    DONE
  } ram_b_state_e;

endpackage

// File: rtl/ram_b_loader_byte_packer.sv
// Packs a stream of bytes into one RAM_B word, first byte in the least significant lane.
module byte_packer
  import ram_b_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    take,
  input  logic                    clear,
  input  logic [7:0]              data,
  output logic [RAM_B_DATA_W-1:0] word,
  output logic                    word_full
);

  logic [1:0] cnt;

  // High on the take that completes the word; the loader uses it to leave COLLECT.
  assign word_full = take && (cnt == 2'(BYTES_PER_WORD - 1));

  // Byte lane counter and lane insert; the counter wraps to 0 after the last lane.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (take) begin
      cnt               <= cnt + 2'd1;
      word[8*cnt +: 8]  <= data;
    end
  end

endmodule

// File: rtl/ram_b_loader.sv
// Writer-side master for RAM_B port A: loads WORDS packed words, reads them back
// and flags a checksum mismatch to the boot sequencer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start after reset
// COLLECT | accepting bytes into the packer (byte_ready=1)
// WRITE   | single cycle with wea=1, checksum accumulates dina
// VERIFY  | reading addresses 0..WORDS-1 back, plus one drain cycle
// DONE    | done=1, err valid; start begins a new run
module ram_b_loader
  import ram_b_pkg::*;
#(
  parameter int WORDS  = RAM_B_DEPTH,
  parameter int ADDR_W = RAM_B_ADDR_W,
  parameter int DATA_W = RAM_B_DATA_W
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] sum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  ram_b_state_e      state;
  logic              take;
  logic              word_full;
  logic              pk_clear;
  logic              rd_valid;
  logic              last_issued;
  logic [DATA_W-1:0] rb_sum;
  logic [DATA_W-1:0] rb_next;

  assign take     = byte_valid && byte_ready;
  assign pk_clear = (((state == IDLE) || (state == DONE)) && start)
                 || ((state == WRITE) && (addra != LAST_ADDR));
  // Read data arrives one cycle after its address, so only words flagged by rd_valid count.
  assign rb_next  = rb_sum + (rd_valid ? douta : '0);

  byte_packer u_packer (
    .clk       (clka),
    .rst       (rsta),
    .take      (take),
    .clear     (pk_clear),
    .data      (byte_in),
    .word      (dina),
    .word_full (word_full)
  );

  // Sequencer: collect/write per word, then read-back verify and report.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state       <= IDLE;
      byte_ready  <= 1'b0;
      wea         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      addra       <= '0;
      sum         <= '0;
      rb_sum      <= '0;
      rd_valid    <= 1'b0;
      last_issued <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= COLLECT;
            addra       <= '0;
            sum         <= '0;
            rb_sum      <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b1;
            byte_ready  <= 1'b1;
            last_issued <= 1'b0;
          end
        end
        COLLECT: begin
          if (take && word_full) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            wea        <= 1'b1;
          end
        end
        WRITE: begin
          wea <= 1'b0;
          sum <= sum + dina;
          if (addra == LAST_ADDR) begin
            state <= VERIFY;
            addra <= '0;
          end else begin
            state      <= COLLECT;
            addra      <= addra + 1'b1;
            byte_ready <= 1'b1;
          end
        end
        VERIFY: begin
          rb_sum <= rb_next;
          if (last_issued) begin
            // Drain cycle: the last word is in douta now, so the final compare uses rb_next.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= (rb_next != sum);
          end else begin
            rd_valid <= 1'b1;
            if (addra == LAST_ADDR) begin
              last_issued <= 1'b1;
            end else begin
              addra <= addra + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
